// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// One request is outstanding at a time; ready is a single-cycle response pulse.
interface fetch_stage_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// CX3001 instruction fetch stage: owns the PC, issues one-outstanding imem
// requests and feeds the IF/ID register through a one-entry skid buffer.
module fetch_stage #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    fetch_stage_if.master      imem,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               ifid_valid,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc_plus1,
    output logic [3:0]         op_code
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_FULL,
        S_DROP
    } state_t;

    state_t             state, state_n;
    logic [ADDR_W-1:0]  pc, pc_n;
    logic [ADDR_W-1:0]  fetch_addr, fetch_addr_n;
    logic [INSTR_W-1:0] skid_instr, skid_instr_n;
    logic [ADDR_W-1:0]  skid_pc1, skid_pc1_n;
    logic               ifid_valid_n;
    logic [INSTR_W-1:0] ifid_instr_n;
    logic [ADDR_W-1:0]  ifid_pc1_n;
    logic [ADDR_W-1:0]  fetch_inc;
    logic               ifid_free;

    assign fetch_inc      = fetch_addr + ADDR_W'(1);
    assign ifid_free      = !stall || !ifid_valid;
    assign imem.imem_req  = (state == S_REQ) || (state == S_DROP);
    assign imem.imem_addr = fetch_addr;
    assign op_code        = ifid_instr[INSTR_W-1 -: 4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            pc            <= RESET_PC;
            fetch_addr    <= RESET_PC;
            skid_instr    <= '0;
            skid_pc1      <= '0;
            ifid_valid    <= 1'b0;
            ifid_instr    <= '0;
            ifid_pc_plus1 <= '0;
        end else begin
            state         <= state_n;
            pc            <= pc_n;
            fetch_addr    <= fetch_addr_n;
            skid_instr    <= skid_instr_n;
            skid_pc1      <= skid_pc1_n;
            ifid_valid    <= ifid_valid_n;
            ifid_instr    <= ifid_instr_n;
            ifid_pc_plus1 <= ifid_pc1_n;
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        fetch_addr_n = fetch_addr;
        skid_instr_n = skid_instr;
        skid_pc1_n   = skid_pc1;
        ifid_valid_n = ifid_valid;
        ifid_instr_n = ifid_instr;
        ifid_pc1_n   = ifid_pc_plus1;

        if (branch_taken) begin
            ifid_valid_n = 1'b0;
            ifid_instr_n = '0;
            ifid_pc1_n   = '0;
            skid_instr_n = '0;
            skid_pc1_n   = '0;
            pc_n         = branch_target;
            // An unanswered request must still complete on the bus, so its
            // address is kept and the response is dropped in S_DROP.
            case (state)
                S_REQ: begin
                    if (imem.imem_ready) begin
                        fetch_addr_n = branch_target;
                        state_n      = S_REQ;
                    end else begin
                        state_n      = S_DROP;
                    end
                end
                S_DROP: state_n = S_DROP;
                default: begin
                    fetch_addr_n = branch_target;
                    state_n      = S_REQ;
                end
            endcase
        end else begin
            if (ifid_free) begin
                ifid_valid_n = 1'b0;
                ifid_instr_n = '0;
                ifid_pc1_n   = '0;
            end
            case (state)
                S_IDLE: state_n = S_REQ;
                S_REQ: begin
                    if (imem.imem_ready) begin
                        pc_n         = fetch_inc;
                        fetch_addr_n = fetch_inc;
                        if (ifid_free) begin
                            ifid_valid_n = 1'b1;
                            ifid_instr_n = imem.imem_rdata;
                            ifid_pc1_n   = fetch_inc;
                        end else begin
                            skid_instr_n = imem.imem_rdata;
                            skid_pc1_n   = fetch_inc;
                            state_n      = S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    if (!stall) begin
                        ifid_valid_n = 1'b1;
                        ifid_instr_n = skid_instr;
                        ifid_pc1_n   = skid_pc1;
                        skid_instr_n = '0;
                        skid_pc1_n   = '0;
                        state_n      = S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem.imem_ready) begin
                        fetch_addr_n = pc;
                        state_n      = S_REQ;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

endmodule
